uart_rx: RTL and testbench

- UART receiver: the receive end of the UART link. Deserialises an asynchronous 8N1 serial line into parallel bytes for the processor's UART peripheral.
- Runs on the processor clock. Samples the line with a 16x oversampling tick.
- Delivers each byte through a level-valid / read-strobe handshake.
- Reports framing and overrun errors as sticky flags.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 34 +++
 rtl/uart_rx.sv | 153 +++++++++++++++
 tb/tb_uart_rx.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the baud divider calculation used by both receiver and transmitter.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

  // Clock cycles per oversampling tick (integer division, rounds down).
  function automatic int calc_div(input int clk_freq, input int baud_rate,
                                  input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Programmable tick divider. Counts 0..DIV-1 while enabled and emits a
// one-clock tick on the last count; held at zero while disabled so every
// enable starts a fresh, phase-aligned period.
`timescale 1ns/1ps
module uart_baud_tick #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Divider counter: restart on disable or at the end of each period.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver. Synchronises the serial line, oversamples it 16x,
// deserialises LSB-first frames and presents each byte through a
// level-valid / read-strobe handshake with sticky framing/overrun flags.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  input  logic                 rx_rd_i,
  input  logic                 err_clr_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 frame_err_o,
  output logic                 overrun_err_o,
  output logic                 busy_o
);

  import uart_pkg::*;

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [3:0]     LAST_SAMPLE = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]     MID         = 4'(MID_SAMPLE);
  localparam logic [BCW-1:0] LAST_BIT    = BCW'(DATA_BITS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_rx: DIV = %0d is below 2; raise CLK_FREQ or lower BAUD_RATE", DIV);
  end

  rx_state_t          state;
  logic [1:0]         sync_q;
  logic               rx_s;
  logic [3:0]         s_cnt;
  logic [BCW-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic               tick;
  logic               good_stop;
  logic               bad_stop;

  // Two-flop synchroniser for the asynchronous serial line.
  // NOTE: the flops reset to 1 (line idle) so leaving reset never looks
  // like a falling start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_i};
    end
  end

  assign rx_s = sync_q[1];

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state != IDLE),
    .tick  (tick)
  );

  assign good_stop = (state == STOP) && tick && (s_cnt == LAST_SAMPLE) &&  rx_s;
  assign bad_stop  = (state == STOP) && tick && (s_cnt == LAST_SAMPLE) && !rx_s;

  // Frame FSM plus the byte/flag registers it drives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      s_cnt         <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      rx_data_o     <= '0;
      rx_valid_o    <= 1'b0;
      frame_err_o   <= 1'b0;
      overrun_err_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            s_cnt   <= '0;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (s_cnt == MID) begin
              // A line that has returned high by mid start bit was a glitch.
              s_cnt <= '0;
              state <= rx_s ? IDLE : DATA;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            s_cnt <= (s_cnt == LAST_SAMPLE) ? '0 : s_cnt + 1'b1;
            if (s_cnt == LAST_SAMPLE) begin
              shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
                state <= STOP;
              end
            end
          end
        end
        STOP: begin
          if (tick) begin
            s_cnt <= (s_cnt == LAST_SAMPLE) ? '0 : s_cnt + 1'b1;
            if (s_cnt == LAST_SAMPLE) begin
              state <= rx_s ? IDLE : BRK;
            end
          end
        end
        BRK: begin
          // Hold off until the line idles so a break is not seen as a start.
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (good_stop) begin
        rx_data_o  <= shift_reg;
        rx_valid_o <= 1'b1;
      end else if (rx_rd_i) begin
        rx_valid_o <= 1'b0;
      end

      // A new error event wins over a simultaneous clear.
      if (good_stop && rx_valid_o && !rx_rd_i) begin
        overrun_err_o <= 1'b1;
      end else if (err_clr_i) begin
        overrun_err_o <= 1'b0;
      end

      if (bad_stop) begin
        frame_err_o <= 1'b1;
      end else if (err_clr_i) begin
        frame_err_o <= 1'b0;
      end
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at DIV=10 (160 clk per bit). A frame-level
// model predicts each output change from line events; a compare process
// checks every cycle outside short windows around predicted changes, and
// literal spot checks pin exact latencies and values.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD_RATE = 10_000;
  localparam int DATA_BITS = 8;
  localparam int BIT       = 160;
  // Start edge to output change: 2 sync + 1 detect, then half a start bit
  // (glitch decision) or 9.5 bits (stop sample).
  localparam int START_EVT = 3 + BIT / 2;
  localparam int STOP_EVT  = 3 + (1 + DATA_BITS) * BIT + BIT / 2;
  localparam int TOL       = 2;

  typedef enum {EV_BUSY_ON, EV_BUSY_OFF, EV_BYTE, EV_BYTE_RD, EV_FERR,
                EV_READ, EV_CLR} ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_i;
  logic       rx_rd_i;
  logic       err_clr_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       frame_err_o;
  logic       overrun_err_o;
  logic       busy_o;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .DATA_BITS (DATA_BITS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_i          (rx_i),
    .rx_rd_i       (rx_rd_i),
    .err_clr_i     (err_clr_i),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .frame_err_o   (frame_err_o),
    .overrun_err_o (overrun_err_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state
  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ferr  = 1'b0;
  logic       m_oerr  = 1'b0;
  logic       m_busy  = 1'b0;
  int         gen        = 0;
  int         skip_until = -1;
  bit         chk_en     = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [11:0] dut_vec();
    return {busy_o, overrun_err_o, frame_err_o, rx_valid_o, rx_data_o};
  endfunction

  function automatic logic [11:0] m_vec();
    return {m_busy, m_oerr, m_ferr, m_valid, m_data};
  endfunction

  task automatic check(input string name, input logic [11:0] act,
                       input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s at cycle %0d: {busy,oerr,ferr,valid,data} got %03h, want %03h",
                 name, cyc, act, exp);
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Apply one predicted output change at cycle t, masking the compare
  // process for +/-TOL cycles around it. A reset cancels pending events.
  task automatic model_event(input int t, input ev_t kind, input logic [7:0] d);
    int g;
    g = gen;
    wait_to(t - TOL);
    if (g != gen) return;
    if (t + TOL > skip_until) skip_until = t + TOL;
    wait_to(t + TOL);
    if (g != gen) return;
    case (kind)
      EV_BUSY_ON:  m_busy = 1'b1;
      EV_BUSY_OFF: m_busy = 1'b0;
      EV_BYTE: begin
        if (m_valid) m_oerr = 1'b1;
        m_data  = d;
        m_valid = 1'b1;
        m_busy  = 1'b0;
      end
      EV_BYTE_RD: begin
        m_data  = d;
        m_valid = 1'b1;
        m_busy  = 1'b0;
      end
      EV_FERR: m_ferr = 1'b1;
      EV_READ: m_valid = 1'b0;
      EV_CLR: begin
        m_ferr = 1'b0;
        m_oerr = 1'b0;
      end
      default: ;
    endcase
  endtask

  // Drive one frame on the line with the given bit period; rd_same marks a
  // read strobe the caller places on the load cycle.
  task automatic send_frame(input logic [7:0] d, input bit stop, input int per,
                            input bit rd_same);
    int e;
    e = cyc;
    fork
      model_event(e + 3, EV_BUSY_ON, 8'h00);
      model_event(e + STOP_EVT, stop ? (rd_same ? EV_BYTE_RD : EV_BYTE) : EV_FERR, d);
    join_none
    rx_i = 1'b0;
    wait_cyc(per);
    for (int i = 0; i < DATA_BITS; i++) begin
      rx_i = d[i];
      wait_cyc(per);
    end
    rx_i = stop;
    wait_cyc(per);
  endtask

  task automatic read_pulse();
    int c;
    c = cyc;
    fork
      model_event(c + 1, EV_READ, 8'h00);
    join_none
    rx_rd_i = 1'b1;
    wait_cyc(1);
    rx_rd_i = 1'b0;
  endtask

  task automatic clear_pulse();
    int c;
    c = cyc;
    fork
      model_event(c + 1, EV_CLR, 8'h00);
    join_none
    err_clr_i = 1'b1;
    wait_cyc(1);
    err_clr_i = 1'b0;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en && cyc > skip_until) check("cycle", dut_vec(), m_vec());
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e, h;
    rst_n = 1'b1; rx_i = 1'b1; rx_rd_i = 1'b0; err_clr_i = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("reset", dut_vec(), 12'h000);
    wait_cyc(3);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    wait_cyc(20);

    // Good frame 0xA5 with exact valid latency
    e = cyc;
    fork
      send_frame(8'hA5, 1'b1, BIT, 1'b0);
      begin
        wait_to(e + STOP_EVT - 1);
        @(negedge clk) check("a5_before_load", dut_vec(), 12'h800);
        wait_to(e + STOP_EVT);
        @(negedge clk) check("a5_load", dut_vec(), 12'h1A5);
      end
    join
    check("a5_held", dut_vec(), 12'h1A5);
    read_pulse();
    check("a5_read", dut_vec(), 12'h0A5);
    wait_cyc(10);
    read_pulse();
    check("read_when_empty", dut_vec(), 12'h0A5);

    // Glitch shorter than half a bit
    wait_cyc(20);
    e = cyc;
    fork
      model_event(e + 3, EV_BUSY_ON, 8'h00);
      model_event(e + START_EVT, EV_BUSY_OFF, 8'h00);
    join_none
    rx_i = 1'b0;
    wait_cyc(50);
    rx_i = 1'b1;
    wait_cyc(10);
    check("glitch_in_start", dut_vec(), 12'h8A5);
    wait_to(e + START_EVT + 5);
    check("glitch_rejected", dut_vec(), 12'h0A5);

    // Framing error followed by a long break
    wait_cyc(20);
    send_frame(8'h3C, 1'b0, BIT, 1'b0);
    wait_cyc(400);
    check("break_held", dut_vec(), 12'hAA5);
    h = cyc;
    fork
      model_event(h + 3, EV_BUSY_OFF, 8'h00);
    join_none
    rx_i = 1'b1;
    wait_cyc(10);
    check("break_released", dut_vec(), 12'h2A5);
    clear_pulse();
    check("ferr_cleared", dut_vec(), 12'h0A5);

    // Overrun: two back-to-back frames, no read
    wait_cyc(20);
    send_frame(8'h11, 1'b1, BIT, 1'b0);
    send_frame(8'h22, 1'b1, BIT, 1'b0);
    check("overrun", dut_vec(), 12'h522);
    clear_pulse();
    check("oerr_cleared", dut_vec(), 12'h122);
    read_pulse();
    check("overrun_read", dut_vec(), 12'h022);

    // Same pair, read strobe on the cycle the second byte loads
    wait_cyc(20);
    send_frame(8'h11, 1'b1, BIT, 1'b0);
    e = cyc;
    fork
      send_frame(8'h22, 1'b1, BIT, 1'b1);
      begin
        wait_to(e + STOP_EVT - 1);
        rx_rd_i = 1'b1;
        wait_to(e + STOP_EVT);
        rx_rd_i = 1'b0;
      end
    join
    check("read_on_load", dut_vec(), 12'h122);

    // Reset during bit 4 of 0xFF
    wait_cyc(20);
    e = cyc;
    fork
      model_event(e + 3, EV_BUSY_ON, 8'h00);
    join_none
    rx_i = 1'b0;
    wait_cyc(BIT);
    rx_i = 1'b1;
    wait_cyc(4 * BIT + BIT / 2);
    check("mid_frame", dut_vec(), 12'h922);
    #2 rst_n = 1'b0;
    gen++;
    m_busy = 1'b0; m_oerr = 1'b0; m_ferr = 1'b0; m_valid = 1'b0; m_data = 8'h00;
    #1 check("reset_mid_frame", dut_vec(), 12'h000);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(20);
    send_frame(8'h5A, 1'b1, BIT, 1'b0);
    check("after_reset", dut_vec(), 12'h15A);
    read_pulse();

    // Bit-rate tolerance: +3% and -3% bit periods
    wait_cyc(20);
    send_frame(8'h55, 1'b1, 165, 1'b0);
    check("slow_55", dut_vec(), 12'h155);
    read_pulse();
    wait_cyc(20);
    send_frame(8'h00, 1'b1, 155, 1'b0);
    check("fast_00", dut_vec(), 12'h100);
    read_pulse();
    check("final_empty", dut_vec(), 12'h000);

    wait_cyc(50);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
